test_result_port: RTL and testbench

//  Memory-mapped responder for self-checking CPU regression programs. It snoops
//  CPU bus writes, captures the byte written to the result location and, on a

---
 rtl/test_result_port.sv | 165 ++++++++++++++++
 tb/tb_test_result_port.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_port.sv
`default_nettype none
// ============================================================================
//  Module      : test_result_port
//  Description : Bus-snooping verdict port for self-checking CPU regression
//                programs. Captures writes to the result location, compares
//                the final byte against an expected signature when the
//                program writes the completion location, and reports
//                done/pass/fail. A watchdog ends runs that never complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_result_port #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR    = 16'h01DD,
    parameter logic [ADDR_WIDTH-1:0] DONE_ADDR      = 16'h01FF,
    parameter logic [DATA_WIDTH-1:0] EXPECT         = 8'h6E,
    parameter int                    TIMEOUT_CYCLES = 240
) (
    input  logic                  ph2,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] result,
    output logic [7:0]            write_count,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout
);

    // Watchdog counter is wide enough to hold TIMEOUT_CYCLES-1 with headroom.
    localparam int                C_CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        C_WC_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_result_next;
    logic [7:0]            r_wcount;
    logic [7:0]            w_wcount_next;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_CNT_W-1:0]    w_cnt_next;
    logic                  r_done;
    logic                  w_done_next;
    logic                  r_pass;
    logic                  w_pass_next;
    logic                  r_fail;
    logic                  w_fail_next;
    logic                  r_timeout;
    logic                  w_timeout_next;

    logic                  w_result_hit;
    logic                  w_done_hit;
    logic                  w_match;

    assign w_result_hit = write_en && (address == RESULT_ADDR);
    assign w_done_hit   = write_en && (address == DONE_ADDR);
    // A run that never wrote the result location cannot pass, even when the
    // cleared result happens to equal the signature.
    assign w_match      = (r_result == EXPECT) && (r_wcount != 8'd0);

    // Next-state, capture and verdict logic; every target holds by default.
    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_wcount_next  = r_wcount;
        w_cnt_next     = r_cnt;
        w_done_next    = r_done;
        w_pass_next    = r_pass;
        w_fail_next    = r_fail;
        w_timeout_next = r_timeout;

        if (start) begin
            // Start clears and re-arms from any state; a same-cycle write is dropped.
            w_state_next   = ST_ARMED;
            w_result_next  = '0;
            w_wcount_next  = 8'd0;
            w_cnt_next     = '0;
            w_done_next    = 1'b0;
            w_pass_next    = 1'b0;
            w_fail_next    = 1'b0;
            w_timeout_next = 1'b0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_result_hit) begin
                        w_result_next = data_in;
                        if (r_wcount != C_WC_MAX) begin
                            w_wcount_next = r_wcount + 8'd1;
                        end
                    end
                    // Completion write wins over a watchdog expiry in the same cycle.
                    if (w_done_hit) begin
                        w_state_next = ST_CHECK;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_state_next   = ST_DONE;
                        w_done_next    = 1'b1;
                        w_timeout_next = 1'b1;
                        w_fail_next    = 1'b1;
                        w_pass_next    = 1'b0;
                    end
                end
                ST_CHECK: begin
                    w_state_next   = ST_DONE;
                    w_done_next    = 1'b1;
                    w_pass_next    = w_match;
                    w_fail_next    = !w_match;
                    w_timeout_next = 1'b0;
                end
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset overrides start and all bus activity.
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_wcount  <= 8'd0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_wcount  <= w_wcount_next;
            r_cnt     <= w_cnt_next;
            r_done    <= w_done_next;
            r_pass    <= w_pass_next;
            r_fail    <= w_fail_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign result      = r_result;
    assign write_count = r_wcount;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_test_result_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_result_port
//  Description : Self-checking bench for test_result_port. A behavioural
//                model tracks the expected verdict from bus activity and is
//                compared against the DUT every cycle; directed scenarios pin
//                literal expectations, then randomized traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_result_port;

    localparam int         TO  = 240;
    localparam logic [15:0] RA  = 16'h01DD;
    localparam logic [15:0] DA  = 16'h01FF;
    localparam logic [7:0]  EXP = 8'h6E;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        write_en = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  result;
    logic [7:0]  write_count;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 ph2 = ~ph2;

    test_result_port #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (8),
        .RESULT_ADDR   (RA),
        .DONE_ADDR     (DA),
        .EXPECT        (EXP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ph2        (ph2),
        .reset      (reset),
        .address    (address),
        .data_in    (data_in),
        .write_en   (write_en),
        .start      (start),
        .result     (result),
        .write_count(write_count),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_valid    = 0;
    bit         m_watching = 0;   // monitor is collecting writes
    bit         m_judging  = 0;   // completion write seen, verdict next edge
    int         edge_no    = 0;
    int         arm_edge   = 0;
    logic [7:0] m_res      = 8'h00;
    int         m_wc       = 0;
    bit         m_done = 0, m_pass = 0, m_fail = 0, m_to = 0;

    task automatic m_clear();
        m_res = 8'h00; m_wc = 0;
        m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
    endtask

    always @(posedge ph2) begin
        edge_no++;
        if (reset) begin
            m_clear();
            m_watching = 0; m_judging = 0; m_valid = 1;
        end else if (start) begin
            m_clear();
            m_watching = 1; m_judging = 0; arm_edge = edge_no;
        end else if (m_judging) begin
            m_judging = 0;
            m_done = 1;
            m_pass = (m_wc != 0) && (m_res == EXP);
            m_fail = !m_pass;
            m_to   = 0;
        end else if (m_watching) begin
            if (write_en && address == RA) begin
                m_res = data_in;
                if (m_wc < 255) m_wc++;
            end
            if (write_en && address == DA) begin
                m_watching = 0; m_judging = 1;
            end else if (edge_no - arm_edge == TO) begin
                m_watching = 0;
                m_done = 1; m_to = 1; m_fail = 1; m_pass = 0;
            end
        end
    end

    // Compare every cycle on the falling edge, once reset has been applied.
    always @(negedge ph2) begin
        if (m_valid) begin
            chk("m_result",  32'(result),      32'(m_res));
            chk("m_count",   32'(write_count), m_wc);
            chk("m_done",    32'(done),        32'(m_done));
            chk("m_pass",    32'(pass),        32'(m_pass));
            chk("m_fail",    32'(fail),        32'(m_fail));
            chk("m_timeout", 32'(timeout),     32'(m_to));
        end
    end

    // One bus cycle: drive inputs, let one rising edge sample them, settle.
    task automatic cyc(input logic rst, input logic st, input logic we,
                       input logic [15:0] a, input logic [7:0] d);
        reset = rst; start = st; write_en = we; address = a; data_in = d;
        @(posedge ph2);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b1, 1'b1, DA, 8'hFF);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_count", 32'(write_count), 0);

        // 1: correct signature passes; a write during the verdict cycle is ignored
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h6E);
        cyc(1'b0, 1'b0, 1'b1, DA, 8'h00);
        chk("t1_latency", 32'(done), 0);
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h55);
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_fail", 32'(fail), 0);
        chk("t1_result", 32'(result), 32'h6E);
        chk("t1_count", 32'(write_count), 1);

        // 2: wrong signature fails without timeout
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h6D);
        cyc(1'b0, 1'b0, 1'b1, DA, 8'h00);
        idle();
        chk("t2_fail", 32'(fail), 1);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_timeout", 32'(timeout), 0);
        chk("t2_result", 32'(result), 32'h6D);

        // 3: watchdog expires exactly TO edges after start and holds
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        repeat (TO - 1) idle();
        chk("t3_early", 32'(done), 0);
        idle();
        chk("t3_done", 32'(done), 1);
        chk("t3_timeout", 32'(timeout), 1);
        chk("t3_fail", 32'(fail), 1);
        repeat (5) idle();
        chk("t3_hold", 32'({done, timeout, fail, pass}), 32'hE);

        // 4: write before start and reads while armed are not counted
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h6E);
        chk("t4_pre", 32'(result), 0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, RA, 8'h6E);
        chk("t4_count", 32'(write_count), 0);
        cyc(1'b0, 1'b0, 1'b1, DA, 8'h00);
        idle();
        chk("t4_fail", 32'(fail), 1);
        chk("t4_pass", 32'(pass), 0);

        // 5: reset mid-run clears everything and later writes are ignored
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h11);
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h6E);
        chk("t5_count", 32'(write_count), 2);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("t5_rst", 32'({result, write_count}), 0);
        cyc(1'b0, 1'b0, 1'b1, DA, 8'h00);
        idle();
        chk("t5_done", 32'(done), 0);

        // 6: completion write on the watchdog's last cycle wins
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, RA, 8'h6E);
        repeat (TO - 2) idle();
        cyc(1'b0, 1'b0, 1'b1, DA, 8'h00);
        chk("t6_mid", 32'(timeout), 0);
        idle();
        chk("t6_pass", 32'(pass), 1);
        chk("t6_timeout", 32'(timeout), 0);

        // Randomized traffic; odd segments rarely complete so the watchdog fires
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 700; i++) begin
                int          r;
                int          r2;
                int          pdone;
                int          st_hi;
                logic        rst;
                logic        st;
                logic        we;
                logic [15:0] a;
                logic [7:0]  d;
                r     = $urandom_range(0, 999);
                r2    = $urandom_range(0, 999);
                pdone = (seg % 2 == 0) ? 30 : 1;
                st_hi = (seg % 2 == 0) ? 15 : 5;
                rst   = (r < 3);
                st    = (r >= 3) && (r < st_hi);
                we    = 1'($urandom_range(0, 1));
                if (r2 < pdone)    a = DA;
                else if (r2 < 500) a = RA;
                else               a = 16'($urandom);
                d = ($urandom_range(0, 1) == 1) ? EXP : 8'($urandom);
                cyc(rst, st, we, a, d);
            end
        end

        idle();
        @(negedge ph2);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
